symbol_upsample_tx: RTL and testbench
=====================================

Name: symbol_upsample_tx

Overview:
Transmit-side counterpart of the receive decimator that feeds the Gardner loop. Accepts baseband symbols over a valid/ready handshake and buffers them in a small FIFO. A 32-bit NCO produces sample ticks at OSR × symbol rate; each symbol is emitted as OSR samples, either held or zero-stuffed. Output drives the TX shaping filter/DAC path, with a symbol-rate strobe for downstream framing.

Parameters:
DATA_W, 16, symbol/sample width (signed two's complement)
OSR, 4, samples per symbol (2..16)
FIFO_DEPTH, 16, symbol FIFO depth (power of two, 4..64)
PRIME_LEVEL, 4, FIFO level required before output starts (1..FIFO_DEPTH)
ZERO_STUFF, 0, 0 = hold symbol for OSR samples; 1 = symbol on first sample, zeros on the rest

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_sample_FTW  in  32  NCO tuning word; tick period = 2^31/FTW clk cycles (FTW ≤ 0x8000_0000)
i_enable  in  1  run request
i_sym_data  in  DATA_W  input symbol
i_sym_valid  in  1  symbol valid
o_sym_ready  out  1  FIFO not full
o_sample_data  out  DATA_W  output sample
o_sample_valid  out  1  one-clk pulse per sample tick while RUN/DRAIN
o_sym_strobe  out  1  one-clk pulse coincident with o_sample_valid on sample index 0
o_underflow  out  1  sticky underflow flag
i_clr_underflow  in  1  clears o_underflow
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0, async): phase=0, FSM=IDLE, FIFO empty, sample index=0. Outputs: o_sample_data=0, o_sample_valid=0, o_sym_strobe=0, o_underflow=0, o_fifo_level=0, o_sym_ready=0 while reset is asserted, 1 after release.
- NCO: phase <= {1'b0, phase[30:0]} + i_sample_FTW on every clk while in PRIME, RUN or DRAIN; held at 0 in IDLE. tick = phase[31] (registered). FTW=0 → no ticks. FTW changes take effect on the next add.
- FIFO: a push occurs when i_sym_valid & o_sym_ready. o_sym_ready = !full and is independent of FSM state, so the FIFO fills in IDLE. A push and pop in the same cycle are both legal; level is unchanged (at full, ready stays 0 and only the pop occurs).
- FSM:
  - IDLE: outputs 0, no valid pulses. Go to PRIME when i_enable=1.
  - PRIME: ticks are ignored and the index is held at 0. Go to RUN when level ≥ PRIME_LEVEL. Go to IDLE if i_enable=0.
  - RUN, on each tick:
    - index 0: pop a symbol into the current register, or load 0 and set o_underflow if the FIFO is empty. Assert o_sym_strobe.
    - Sample output is cur when ZERO_STUFF=0. When ZERO_STUFF=1 it is cur at index 0 and 0 otherwise.
    - index <= (index==OSR-1) ? 0 : index+1.
    - If i_enable=0 at a tick, go to DRAIN; if index has just wrapped to 0, go directly to IDLE.
  - RUN underflow does not leave RUN.
  - DRAIN: continue ticks until the index wraps to 0, then go to IDLE. No pops occur in DRAIN, and the remaining FIFO contents are retained.
- Latency: o_sample_data and o_sample_valid are registered and appear 1 clk after the internal tick. Pop happens in the tick cycle.
- o_underflow: set has priority over i_clr_underflow in the same cycle.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are discarded.
- Width: no arithmetic on data; zero insertion is all-zero DATA_W.

Decomposition:
- Shared package tx_pkg: FSM state enum (IDLE, PRIME, RUN, DRAIN), NCO width constant (32), FTW helper constants for common rates.
- One sub-module, sync_fifo_tx (parameter DATA_W, DEPTH). It provides push/pop, full/empty and level, and supports simultaneous push and pop.

Test Plan:
1. FTW=0x0800_0000, OSR=4, PRIME_LEVEL=4, ZERO_STUFF=0; push 0x1111, 0x2222, 0x3333, 0x4444; enable → o_sample_valid every 16 clks. Outputs are 0x1111 ×4, then 0x2222 ×4, and so on. o_sym_strobe is asserted every 64 clks.
2. Same stimulus with ZERO_STUFF=1 → sample sequence 0x1111,0,0,0,0x2222,0,0,0,…
3. Push only 4 symbols with enable held high → after 16 samples the next symbol period outputs 0 and o_underflow=1. o_underflow stays set until i_clr_underflow; with clear and underflow in the same cycle it remains 1.
4. Hold i_sym_valid high with enable=0 → level reaches 16 and o_sym_ready=0. Enable → simultaneous push and pop at the boundary keeps level ≤16 with no data loss or duplication; the output order matches push order.
5. Deassert i_enable at sample index 1 → exactly 2 further samples (index 2 and 3) are emitted, then IDLE. Remaining FIFO level is unchanged.
6. Assert rst low mid-RUN → outputs go to 0 within the same cycle (async) and level=0. After release the block stays in IDLE until i_enable, and FTW=0 yields no valid pulses.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the symbol upsampler: FSM states, NCO width and
// tuning words for common sample-tick rates.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

    localparam int NCO_W = 32;

    // Tick period = 2^31 / FTW clocks.
    localparam logic [NCO_W-1:0] FTW_DIV1  = 32'h8000_0000;
    localparam logic [NCO_W-1:0] FTW_DIV2  = 32'h4000_0000;
    localparam logic [NCO_W-1:0] FTW_DIV4  = 32'h2000_0000;
    localparam logic [NCO_W-1:0] FTW_DIV8  = 32'h1000_0000;
    localparam logic [NCO_W-1:0] FTW_DIV16 = 32'h0800_0000;

endpackage

// File: rtl/sync_fifo_tx.sv
// Symbol FIFO with show-ahead read data. Push and pop may occur in the same
// cycle. A push when full or a pop when empty is ignored.
module sync_fifo_tx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents carry no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/symbol_upsample_tx.sv
// Transmit symbol upsampler: buffers symbols in a FIFO and emits each one as
// OSR samples (held or zero-stuffed) at ticks from a 32-bit NCO.
module symbol_upsample_tx
    import tx_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int OSR         = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 4,
    parameter int ZERO_STUFF  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NCO_W-1:0]               i_sample_FTW,
    input  logic                           i_enable,
    input  logic [DATA_W-1:0]              i_sym_data,
    input  logic                           i_sym_valid,
    output logic                           o_sym_ready,
    output logic [DATA_W-1:0]              o_sample_data,
    output logic                           o_sample_valid,
    output logic                           o_sym_strobe,
    output logic                           o_underflow,
    input  logic                           i_clr_underflow,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = $clog2(OSR);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(OSR - 1);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [NCO_W-1:0]  phase;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] sym_next;
    logic [DATA_W-1:0] sample_nxt;
    logic              tick;
    logic              fire;
    logic              first_tick;
    logic              at_first;
    logic              at_last;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              underflow_set;

    // Ready only outside reset, so nothing is accepted while the FIFO is being cleared.
    assign o_sym_ready   = rst && !full;
    assign push          = i_sym_valid && o_sym_ready;

    assign tick          = phase[NCO_W-1];
    assign fire          = tick && ((state == RUN) || (state == DRAIN));
    assign at_first      = (idx == '0);
    assign at_last       = (idx == IDX_LAST);
    assign first_tick    = fire && (state == RUN) && at_first;
    assign pop           = first_tick && !empty;
    assign underflow_set = first_tick && empty;
    assign sym_next      = empty ? '0 : fifo_head;
    assign sample_nxt    = at_first ? sym_next : ((ZERO_STUFF != 0) ? '0 : cur);

    sync_fifo_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (i_sym_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (full),
        .empty     (empty),
        .level     (o_fifo_level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; leaving RUN on the last sample skips DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_enable) state_nxt = PRIME;
            PRIME: begin
                if (!i_enable)                        state_nxt = IDLE;
                else if (o_fifo_level >= PRIME_LVL)   state_nxt = RUN;
            end
            RUN:     if (tick && !i_enable) state_nxt = at_last ? IDLE : DRAIN;
            DRAIN:   if (tick && at_last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NCO accumulator: the tick bit is dropped before each add, held at zero in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               phase <= '0;
        else if (state == IDLE) phase <= '0;
        else                    phase <= {1'b0, phase[NCO_W-2:0]} + i_sample_FTW;
    end

    // Sample index within the current symbol; parked at 0 outside RUN/DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     idx <= '0;
        else if (fire)                                idx <= at_last ? '0 : idx + IDX_W'(1);
        else if (state != RUN && state != DRAIN)      idx <= '0;
    end

    // Current symbol register, loaded at index 0 (zero on underflow).
    always_ff @(posedge clk) begin
        if (first_tick) cur <= sym_next;
    end

    // Registered sample outputs, one clock after the tick; data cleared in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sample_valid <= 1'b0;
            o_sym_strobe   <= 1'b0;
            o_sample_data  <= '0;
        end else begin
            o_sample_valid <= fire;
            o_sym_strobe   <= fire && at_first;
            if (fire)               o_sample_data <= sample_nxt;
            else if (state == IDLE) o_sample_data <= '0;
        end
    end

    // Sticky underflow flag; a new underflow wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 o_underflow <= 1'b0;
        else if (underflow_set)   o_underflow <= 1'b1;
        else if (i_clr_underflow) o_underflow <= 1'b0;
    end

endmodule

// File: tb/tb_symbol_upsample_tx.sv
// Testbench for symbol_upsample_tx: a hold-mode and a zero-stuff instance
// share all inputs; samples are collected at the falling edge.
module tb_symbol_upsample_tx;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       i_sample_FTW;
    logic              i_enable;
    logic [DATA_W-1:0] i_sym_data;
    logic              i_sym_valid;
    logic              i_clr_underflow;
    logic              o_sym_ready, o_sample_valid, o_sym_strobe, o_underflow;
    logic [DATA_W-1:0] o_sample_data;
    logic [4:0]        o_fifo_level;
    logic              zs_ready, zs_valid, zs_strobe, zs_underflow;
    logic [DATA_W-1:0] zs_data;
    logic [4:0]        zs_level;

    always #5 clk = ~clk;

    symbol_upsample_tx #(.DATA_W(16), .OSR(4), .FIFO_DEPTH(16), .PRIME_LEVEL(4), .ZERO_STUFF(0)) dut (
        .clk(clk), .rst(rst), .i_sample_FTW(i_sample_FTW), .i_enable(i_enable),
        .i_sym_data(i_sym_data), .i_sym_valid(i_sym_valid), .o_sym_ready(o_sym_ready),
        .o_sample_data(o_sample_data), .o_sample_valid(o_sample_valid), .o_sym_strobe(o_sym_strobe),
        .o_underflow(o_underflow), .i_clr_underflow(i_clr_underflow), .o_fifo_level(o_fifo_level));

    symbol_upsample_tx #(.DATA_W(16), .OSR(4), .FIFO_DEPTH(16), .PRIME_LEVEL(4), .ZERO_STUFF(1)) dut_zs (
        .clk(clk), .rst(rst), .i_sample_FTW(i_sample_FTW), .i_enable(i_enable),
        .i_sym_data(i_sym_data), .i_sym_valid(i_sym_valid), .o_sym_ready(zs_ready),
        .o_sample_data(zs_data), .o_sample_valid(zs_valid), .o_sym_strobe(zs_strobe),
        .o_underflow(zs_underflow), .i_clr_underflow(i_clr_underflow), .o_fifo_level(zs_level));

    typedef struct {
        logic [15:0] sym_in;
        logic [15:0] exp_hold;
        logic [15:0] exp_zs;
        logic        exp_strb;
    } vec_t;

    vec_t        vt [16];
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;
    int          max_level = 0;
    logic [15:0] obs_data [$];
    logic [15:0] obs_zs   [$];
    logic        obs_strb [$];
    logic        obs_uf   [$];
    int          obs_t    [$];
    logic [15:0] push_src [$];
    logic [15:0] exp_q    [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next push.
    task automatic cyc();
        @(negedge clk);
        cycle++;
        if (int'(o_fifo_level) > max_level) max_level = int'(o_fifo_level);
        if (o_sample_valid) begin
            obs_data.push_back(o_sample_data);
            obs_zs.push_back(zs_data);
            obs_strb.push_back(o_sym_strobe);
            obs_uf.push_back(o_underflow);
            obs_t.push_back(cycle);
        end
        if (push_src.size() > 0) begin
            i_sym_valid = 1'b1;
            i_sym_data  = push_src[0];
            if (o_sym_ready) exp_q.push_back(push_src.pop_front());
        end else begin
            i_sym_valid = 1'b0;
            i_sym_data  = '0;
        end
    endtask

    task automatic wait_samples(input int n, input int budget, input string name);
        int k = 0;
        while (obs_data.size() < n && k < budget) begin
            cyc();
            k++;
        end
        if (obs_data.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d samples, required %0d", name, obs_data.size(), n);
        end
    endtask

    initial begin
        int n0, g, k, pre;
        logic [4:0] lvl;

        vt[0]  = '{16'h1111, 16'h1111, 16'h1111, 1'b1};
        vt[1]  = '{16'h1111, 16'h1111, 16'h0000, 1'b0};
        vt[2]  = '{16'h1111, 16'h1111, 16'h0000, 1'b0};
        vt[3]  = '{16'h1111, 16'h1111, 16'h0000, 1'b0};
        vt[4]  = '{16'h2222, 16'h2222, 16'h2222, 1'b1};
        vt[5]  = '{16'h2222, 16'h2222, 16'h0000, 1'b0};
        vt[6]  = '{16'h2222, 16'h2222, 16'h0000, 1'b0};
        vt[7]  = '{16'h2222, 16'h2222, 16'h0000, 1'b0};
        vt[8]  = '{16'h3333, 16'h3333, 16'h3333, 1'b1};
        vt[9]  = '{16'h3333, 16'h3333, 16'h0000, 1'b0};
        vt[10] = '{16'h3333, 16'h3333, 16'h0000, 1'b0};
        vt[11] = '{16'h3333, 16'h3333, 16'h0000, 1'b0};
        vt[12] = '{16'h4444, 16'h4444, 16'h4444, 1'b1};
        vt[13] = '{16'h4444, 16'h4444, 16'h0000, 1'b0};
        vt[14] = '{16'h4444, 16'h4444, 16'h0000, 1'b0};
        vt[15] = '{16'h4444, 16'h4444, 16'h0000, 1'b0};

        i_sample_FTW    = 32'h0800_0000;
        i_enable        = 1'b0;
        i_sym_data      = '0;
        i_sym_valid     = 1'b0;
        i_clr_underflow = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid",  o_sample_valid, 0);
        check("rst_data",   o_sample_data,  0);
        check("rst_strobe", o_sym_strobe,   0);
        check("rst_uf",     o_underflow,    0);
        check("rst_level",  o_fifo_level,   0);
        check("rst_ready",  o_sym_ready,    0);
        rst = 1'b1;
        cyc();
        check("ready_after_rst", o_sym_ready, 1);

        // Hold and zero-stuff sequences from four primed symbols.
        for (int i = 0; i < 16; i += 4) push_src.push_back(vt[i].sym_in);
        repeat (6) cyc();
        check("prime_level", o_fifo_level, 4);
        check("idle_no_valid", obs_data.size(), 0);
        i_enable = 1'b1;
        wait_samples(17, 2000, "run_samples");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("hold[%0d]", i), obs_data[i], vt[i].exp_hold);
            check($sformatf("zs[%0d]", i),   obs_zs[i],   vt[i].exp_zs);
            check($sformatf("strb[%0d]", i), obs_strb[i], vt[i].exp_strb);
        end
        for (int i = 0; i < 15; i++) check($sformatf("period[%0d]", i), obs_t[i+1] - obs_t[i], 16);
        check("strobe_period", obs_t[4] - obs_t[0], 64);
        check("uf_before", obs_uf[15], 0);

        // Underflow on the fifth symbol, stickiness and clear priority.
        check("uf_hold_data", obs_data[16], 0);
        check("uf_zs_data",   obs_zs[16],   0);
        check("uf_flag",      obs_uf[16],   1);
        check("uf_strobe",    obs_strb[16], 1);
        repeat (5) cyc();
        check("uf_sticky", o_underflow, 1);
        i_clr_underflow = 1'b1;
        cyc();
        check("uf_cleared", o_underflow, 0);
        wait_samples(21, 200, "uf_second");
        for (int i = 17; i < 20; i++) check($sformatf("uf_clr_held[%0d]", i), obs_uf[i], 0);
        check("uf_set_wins", obs_uf[20], 1);
        check("uf_run_data", obs_data[20], 0);
        cyc();
        check("uf_clear_after", o_underflow, 0);
        i_clr_underflow = 1'b0;
        i_enable = 1'b0;
        repeat (100) cyc();
        n0 = obs_data.size();
        repeat (40) cyc();
        check("idle_after_drain", obs_data.size() - n0, 0);
        check("idle_data", o_sample_data, 0);

        // Fill to full while disabled, then run with continuous pushes.
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        obs_data.delete(); obs_zs.delete(); obs_strb.delete(); obs_uf.delete(); obs_t.delete();
        exp_q.delete();
        max_level = 0;
        for (int i = 0; i < 40; i++) push_src.push_back(16'h0100 + 16'(i));
        repeat (30) cyc();
        check("fill_level", o_fifo_level, 16);
        check("fill_ready", o_sym_ready, 0);
        check("fill_count", exp_q.size(), 16);
        i_enable = 1'b1;
        wait_samples(40, 1500, "full_run");
        check("max_level", max_level, 16);
        check("refilled", exp_q.size() > 16, 1);
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 4; j++)
                check($sformatf("order_hold[%0d.%0d]", s, j), obs_data[4*s+j], exp_q[s]);
            check($sformatf("order_zs[%0d]", s),   obs_zs[4*s],   exp_q[s]);
            check($sformatf("order_zs0[%0d]", s),  obs_zs[4*s+1], 0);
            check($sformatf("order_strb[%0d]", s), obs_strb[4*s], 1);
        end

        // Disable right after a sample at index 1: two more samples, then idle.
        push_src.delete();
        i_sym_valid = 1'b0;
        k = 0;
        while (k < 200) begin
            pre = obs_data.size();
            cyc();
            k++;
            if (obs_data.size() != pre && obs_data.size() % 4 == 2) break;
        end
        check("drain_found_idx1", obs_data.size() % 4, 2);
        i_enable = 1'b0;
        lvl = o_fifo_level;
        n0  = obs_data.size();
        g   = (n0 - 1) / 4;
        repeat (100) cyc();
        check("drain_count", obs_data.size() - n0, 2);
        check("drain_level", o_fifo_level, lvl);
        check("drain_data2", obs_data[n0],     exp_q[g]);
        check("drain_data3", obs_data[n0 + 1], exp_q[g]);
        check("drain_strb",  obs_strb[n0],     0);
        check("drain_zs",    obs_zs[n0 + 1],   0);

        // Asynchronous reset in the middle of RUN.
        i_enable = 1'b1;
        wait_samples(n0 + 4, 300, "rerun");
        cyc();
        #2 rst = 1'b0;
        #1;
        check("arst_valid",  o_sample_valid, 0);
        check("arst_strobe", o_sym_strobe,   0);
        check("arst_data",   o_sample_data,  0);
        check("arst_level",  o_fifo_level,   0);
        check("arst_ready",  o_sym_ready,    0);
        i_enable = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        n0 = obs_data.size();
        repeat (60) cyc();
        check("post_rst_idle", obs_data.size() - n0, 0);
        check("post_rst_ready", o_sym_ready, 1);
        check("post_rst_level", o_fifo_level, 0);
        i_sample_FTW = 32'h0;
        for (int i = 0; i < 4; i++) push_src.push_back(16'hA000 + 16'(i));
        i_enable = 1'b1;
        repeat (200) cyc();
        check("ftw0_no_valid", obs_data.size() - n0, 0);
        check("ftw0_level", o_fifo_level, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
